servo_gate_seq: RTL and testbench
=================================

// Module: servo_gate_seq
// PURPOSE
//  Sequences one hobby servo that drives a gate or barrier.
//  Accepts open requests and ramps the pulse width one STEP per 20 ms PWM frame to the open position.
//  Holds open for HOLD_FRAMES, then ramps closed. Reopens on obstruction or on a new request.
//  Contains its own PWM frame generator; servo_pwm drives the servo pin directly.
// PARAMETERS
//  FRAME_CYCLES  1_000_000  PWM period in clk cycles (20 ms @ 50 MHz)
//  PW_CLOSED     100_000    pulse width at closed position, cycles
//  PW_OPEN       50_000     pulse width at open position, cycles (must be < PW_CLOSED)
//  STEP          2_500      pulse-width change per frame while moving (>0)
//  HOLD_FRAMES   150        frames to stay open after arrival (3 s)
// PORTS
//  clk          in   1   system clock
//  rst_n        in   1   asynchronous reset, active low
//  enable       in   1   when low, open_req is ignored (never acked); motion in progress completes
//  open_req     in   1   level request to open; sampled every clk
//  obstruct     in   1   obstruction sensor, active high
//  open_ack     out  1   1-cycle pulse: request accepted
//  busy         out  1   state != CLOSED
//  is_open      out  1   state == OPEN_HOLD
//  closed_done  out  1   1-cycle pulse on CLOSING->CLOSED
//  servo_pwm    out  1   PWM to servo, registered
// BEHAVIOUR
//  Reset: state=CLOSED, pw_cur=PW_CLOSED, frame_cnt=0, hold_cnt=0, all outputs 0.
//  Frame: frame_cnt counts 0..FRAME_CYCLES-1 and wraps. frame_tick=(frame_cnt==FRAME_CYCLES-1).
//   servo_pwm <= (frame_cnt < pw_cur), so it has 1 cycle latency.
//   pw_cur changes only on frame_tick, so a pulse is never truncated or doubled.
//  Request is accepted if enable && open_req && state is CLOSED, CLOSING or OPEN_HOLD.
//   Acceptance registers open_ack=1 for the next cycle.
//   A held-high open_req re-acks every cycle while accept conditions hold.
//  CLOSED: pw_cur=PW_CLOSED. On accept -> OPENING.
//  OPENING: on frame_tick, pw_cur <= max(pw_cur-STEP, PW_OPEN).
//   When the new value == PW_OPEN -> OPEN_HOLD, hold_cnt<=HOLD_FRAMES-1.
//  OPEN_HOLD: on accept or obstruct, hold_cnt<=HOLD_FRAMES-1 (extend).
//   On frame_tick with hold_cnt==0 and !obstruct -> CLOSING.
//   Otherwise decrement on frame_tick. Reload wins over decrement.
//  CLOSING: on accept or obstruct -> OPENING immediately; pw_cur does not step that cycle even on frame_tick.
//   Else on frame_tick, pw_cur <= min(pw_cur+STEP, PW_CLOSED).
//   Reaching PW_CLOSED -> CLOSED, closed_done=1 for 1 cycle.
//  Arithmetic: pw_cur 17 bits, frame_cnt 20 bits, hold_cnt 8 bits.
//   Saturate at both ends; STEP need not divide (PW_CLOSED-PW_OPEN).
//  Async reset mid-ramp returns to CLOSED/PW_CLOSED at once; the servo is commanded closed from the next frame.
//  obstruct has no effect in CLOSED or OPENING.
// STRUCTURE
//  Shared header servo_defs.vh: state encodings, default timing constants, widths.
//  Sub-module servo_pwm_gen (frame counter, frame_tick, comparator -> servo_pwm).
//  The FSM, hold counter and pw_cur live in this module.
// TESTING (sim params: FRAME_CYCLES=100, PW_CLOSED=20, PW_OPEN=10, STEP=5, HOLD_FRAMES=3)
//  Reset -> servo_pwm high 20 cycles per 100; busy=0; no ack.
//  1-cycle open_req -> open_ack next cycle; widths 15,10; is_open.
//   Then 3 frames later widths 15,20; closed_done pulse; busy=0.
//  obstruct held in OPEN_HOLD -> stays open; after release, 3 more frames, then closes.
//  open_req during CLOSING at width 15 -> ack; next frame width 10; is_open.
//  enable=0 + open_req -> no ack, stays CLOSED.
//   rst_n low mid-OPENING -> outputs 0 asynchronously; after release width 20.
//  STEP=3 -> widths 17,14,11,10; closing 13,16,19,20 (saturation both ends).

Source files
------------

// File: rtl/servo_gate_seq_pkg.sv
// Shared definitions for the gate servo sequencer: state encoding, register widths
// and the default 50 MHz timing constants.
package servo_gate_seq_pkg;

    typedef enum logic [1:0] {
        ST_CLOSED    = 2'd0,
        ST_OPENING   = 2'd1,
        ST_OPEN_HOLD = 2'd2,
        ST_CLOSING   = 2'd3
    } state_t;

    localparam int PW_W    = 17;
    localparam int FRAME_W = 20;
    localparam int HOLD_W  = 8;

    localparam int unsigned DEF_FRAME_CYCLES = 1_000_000;
    localparam int unsigned DEF_PW_CLOSED    = 100_000;
    localparam int unsigned DEF_PW_OPEN      = 50_000;
    localparam int unsigned DEF_STEP         = 2_500;
    localparam int unsigned DEF_HOLD_FRAMES  = 150;

endpackage

// File: rtl/servo_gate_seq_pwm_gen.sv
// PWM frame generator: free-running frame counter, end-of-frame tick and a
// registered width comparator that drives the servo pin.
module servo_gate_seq_pwm_gen
    import servo_gate_seq_pkg::*;
#(
    parameter int unsigned FRAME_CYCLES = DEF_FRAME_CYCLES
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [PW_W-1:0] pw_cur,
    output logic            frame_tick,
    output logic            servo_pwm
);

    localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(FRAME_CYCLES - 1);

    logic [FRAME_W-1:0] frame_cnt;
    logic [FRAME_W-1:0] pw_ext;

    assign frame_tick = (frame_cnt == FRAME_LAST);
    assign pw_ext     = {{(FRAME_W - PW_W){1'b0}}, pw_cur};

    // pw_cur only moves on frame_tick, so the compare sees one width per frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
            servo_pwm <= 1'b0;
        end else begin
            frame_cnt <= frame_tick ? '0 : frame_cnt + 1'b1;
            servo_pwm <= (frame_cnt < pw_ext);
        end
    end

endmodule

// File: rtl/servo_gate_seq.sv
// Gate/barrier servo sequencer: ramps the pulse width open one step per frame,
// holds, ramps closed, and reopens on obstruction or a fresh request.
module servo_gate_seq
    import servo_gate_seq_pkg::*;
#(
    parameter int unsigned FRAME_CYCLES = DEF_FRAME_CYCLES,
    parameter int unsigned PW_CLOSED    = DEF_PW_CLOSED,
    parameter int unsigned PW_OPEN      = DEF_PW_OPEN,
    parameter int unsigned STEP         = DEF_STEP,
    parameter int unsigned HOLD_FRAMES  = DEF_HOLD_FRAMES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic open_req,
    input  logic obstruct,
    output logic open_ack,
    output logic busy,
    output logic is_open,
    output logic closed_done,
    output logic servo_pwm
);

    localparam logic [PW_W-1:0]   PW_CLOSED_L = PW_W'(PW_CLOSED);
    localparam logic [PW_W-1:0]   PW_OPEN_L   = PW_W'(PW_OPEN);
    localparam logic [PW_W-1:0]   STEP_L      = PW_W'(STEP);
    localparam logic [HOLD_W-1:0] HOLD_LOAD   = HOLD_W'(HOLD_FRAMES - 1);

    state_t            state;
    logic [PW_W-1:0]   pw_cur;
    logic [HOLD_W-1:0] hold_cnt;
    logic              frame_tick;
    logic              accept;
    logic [PW_W-1:0]   pw_dec;
    logic [PW_W-1:0]   pw_inc;

    // One extra bit keeps the limit tests free of wrap-around.
    function automatic logic [PW_W-1:0] sat_toward_open(input logic [PW_W-1:0] pw);
        logic [PW_W:0] floor_pw;
        floor_pw = {1'b0, PW_OPEN_L} + {1'b0, STEP_L};
        if ({1'b0, pw} < floor_pw)
            return PW_OPEN_L;
        return pw - STEP_L;
    endfunction

    function automatic logic [PW_W-1:0] sat_toward_closed(input logic [PW_W-1:0] pw);
        logic [PW_W:0] sum;
        sum = {1'b0, pw} + {1'b0, STEP_L};
        if (sum >= {1'b0, PW_CLOSED_L})
            return PW_CLOSED_L;
        return sum[PW_W-1:0];
    endfunction

    assign pw_dec  = sat_toward_open(pw_cur);
    assign pw_inc  = sat_toward_closed(pw_cur);
    assign accept  = enable && open_req && (state != ST_OPENING);
    assign busy    = (state != ST_CLOSED);
    assign is_open = (state == ST_OPEN_HOLD);

    servo_gate_seq_pwm_gen #(
        .FRAME_CYCLES (FRAME_CYCLES)
    ) u_pwm_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .pw_cur     (pw_cur),
        .frame_tick (frame_tick),
        .servo_pwm  (servo_pwm)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_CLOSED;
            pw_cur      <= PW_CLOSED_L;
            hold_cnt    <= '0;
            open_ack    <= 1'b0;
            closed_done <= 1'b0;
        end else begin
            open_ack    <= accept;
            closed_done <= 1'b0;
            case (state)
                ST_CLOSED: begin
                    pw_cur <= PW_CLOSED_L;
                    if (accept)
                        state <= ST_OPENING;
                end
                ST_OPENING: begin
                    if (frame_tick) begin
                        pw_cur <= pw_dec;
                        if (pw_dec == PW_OPEN_L) begin
                            state    <= ST_OPEN_HOLD;
                            hold_cnt <= HOLD_LOAD;
                        end
                    end
                end
                ST_OPEN_HOLD: begin
                    // a reload always beats the per-frame countdown
                    if (accept || obstruct)
                        hold_cnt <= HOLD_LOAD;
                    else if (frame_tick) begin
                        if (hold_cnt == '0)
                            state <= ST_CLOSING;
                        else
                            hold_cnt <= hold_cnt - 1'b1;
                    end
                end
                ST_CLOSING: begin
                    // reversal freezes the width for this cycle, even on a tick
                    if (accept || obstruct)
                        state <= ST_OPENING;
                    else if (frame_tick) begin
                        pw_cur <= pw_inc;
                        if (pw_inc == PW_CLOSED_L) begin
                            state       <= ST_CLOSED;
                            closed_done <= 1'b1;
                        end
                    end
                end
                default: state <= ST_CLOSED;
            endcase
        end
    end

endmodule

// File: tb/tb_servo_gate_seq.sv
// Randomized scoreboard bench for servo_gate_seq with a frame-level reference model.
module tb_servo_gate_seq;

    localparam int F  = 100;
    localparam int PC = 20;
    localparam int PO = 10;
    localparam int ST = 3;
    localparam int H  = 3;

    localparam int M_CLOSED  = 0;
    localparam int M_OPENING = 1;
    localparam int M_HOLD    = 2;
    localparam int M_CLOSING = 3;

    typedef struct {
        int cyc;
        bit busy;
        bit open;
    } status_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic enable = 1'b0;
    logic open_req = 1'b0;
    logic obstruct = 1'b0;
    logic open_ack, busy, is_open, closed_done, servo_pwm;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int      wq[$];
    int      ackq[$];
    int      doneq[$];
    status_t stq[$];

    int m_mode, m_pw, m_hold, m_fc;

    servo_gate_seq #(
        .FRAME_CYCLES (F),
        .PW_CLOSED    (PC),
        .PW_OPEN      (PO),
        .STEP         (ST),
        .HOLD_FRAMES  (H)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .open_req    (open_req),
        .obstruct    (obstruct),
        .open_ack    (open_ack),
        .busy        (busy),
        .is_open     (is_open),
        .closed_done (closed_done),
        .servo_pwm   (servo_pwm)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = M_CLOSED;
        m_pw   = PC;
        m_hold = 0;
        m_fc   = 0;
        wq.delete();
        ackq.delete();
        doneq.delete();
        stq.delete();
    endtask

    // Advances the reference by the clock edge that is about to happen.
    task automatic model_step(input bit en, input bit req, input bit obs);
        bit tick, acc;
        status_t s;
        tick = (m_fc == F - 1);
        if (m_fc == 0) wq.push_back(m_pw);
        acc = en && req && (m_mode != M_OPENING);
        if (acc) ackq.push_back(cyc + 1);
        case (m_mode)
            M_CLOSED: if (acc) m_mode = M_OPENING;
            M_OPENING: if (tick) begin
                m_pw = (m_pw - ST < PO) ? PO : m_pw - ST;
                if (m_pw == PO) begin
                    m_mode = M_HOLD;
                    m_hold = H - 1;
                end
            end
            M_HOLD: begin
                if (acc || obs) m_hold = H - 1;
                else if (tick) begin
                    if (m_hold == 0) m_mode = M_CLOSING;
                    else m_hold--;
                end
            end
            default: begin
                if (acc || obs) m_mode = M_OPENING;
                else if (tick) begin
                    m_pw = (m_pw + ST > PC) ? PC : m_pw + ST;
                    if (m_pw == PC) begin
                        m_mode = M_CLOSED;
                        doneq.push_back(cyc + 1);
                    end
                end
            end
        endcase
        m_fc = tick ? 0 : m_fc + 1;
        s.cyc  = cyc + 1;
        s.busy = (m_mode != M_CLOSED);
        s.open = (m_mode == M_HOLD);
        stq.push_back(s);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_open_ack"}, open_ack, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_is_open"}, is_open, 0);
        check({tag, "_closed_done"}, closed_done, 0);
        check({tag, "_servo_pwm"}, servo_pwm, 0);
    endtask

    // Monitor: samples just after each rising edge and compares against the queues.
    initial begin
        int run;
        bit exp_ev;
        status_t s;
        run = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                run = 0;
            end else begin
                exp_ev = (ackq.size() > 0 && ackq[0] == cyc);
                if (exp_ev) void'(ackq.pop_front());
                check("open_ack", open_ack, exp_ev);
                exp_ev = (doneq.size() > 0 && doneq[0] == cyc);
                if (exp_ev) void'(doneq.pop_front());
                check("closed_done", closed_done, exp_ev);
                if (stq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL status_missing at cycle %0d: got none expected an entry", cyc);
                end else begin
                    s = stq.pop_front();
                    check("status_cycle", cyc, s.cyc);
                    check("busy", busy, s.busy);
                    check("is_open", is_open, s.open);
                end
                if (servo_pwm) run++;
                else if (run > 0) begin
                    if (wq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL pwm_width at cycle %0d: got pulse %0d expected none", cyc, run);
                    end else
                        check("pwm_width", run, wq.pop_front());
                    run = 0;
                end
            end
        end
    end

    // Driver: random segments of enable/request/obstruction behaviour.
    initial begin
        int len, req_pct, obs_mode;
        bit en_seg, req, obs;
        model_reset();
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        @(posedge clk);
        #2 rst_n = 1'b1;
        for (int seg = 0; seg < 30; seg++) begin
            if (seg == 8 || seg == 17 || seg == 25) begin
                @(negedge clk);
                #2 rst_n = 1'b0;
                #1 check_outputs_zero("async_reset");
                model_reset();
                repeat (3) @(posedge clk);
                #2 rst_n = 1'b1;
            end
            len = $urandom_range(100, 1500);
            en_seg = ($urandom_range(0, 9) != 0);
            case ($urandom_range(0, 3))
                0, 1: req_pct = 0;
                2: req_pct = 1;
                default: req_pct = 40;
            endcase
            obs_mode = $urandom_range(0, 3);
            if (seg == 0) begin
                len = 1500; en_seg = 1'b1; req_pct = 0; obs_mode = 0;
            end else if (seg == 1) begin
                len = 300; en_seg = 1'b0; req_pct = 40; obs_mode = 0;
            end
            for (int i = 0; i < len; i++) begin
                @(negedge clk);
                req = (seg == 0 && i == 0) || ($urandom_range(0, 99) < req_pct);
                case (obs_mode)
                    2: obs = (i < len / 2);
                    3: obs = ($urandom_range(0, 99) < 3);
                    default: obs = 1'b0;
                endcase
                enable   = en_seg;
                open_req = req;
                obstruct = obs;
                model_step(en_seg, req, obs);
            end
        end
        @(negedge clk);
        enable = 1'b0; open_req = 1'b0; obstruct = 1'b0;
        model_step(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
